// File: rtl/line_cut_rotate_scrambler_if.sv
// Pixel/key bundle between the decoder-side driver and the cut-and-rotate scrambler.
interface line_cut_rotate_scrambler_if #(
  parameter int DATA_WIDTH = 10,
  parameter int KEY_WIDTH  = 8
);
  // No backpressure: pix_in_valid/key_valid/pix_out_valid qualify their data
  // on the clk edge they are high; line_start and key_valid are 1-clk pulses.
  logic                  line_start;
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_in_valid;
  logic [KEY_WIDTH-1:0]  key_in;
  logic                  key_valid;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] pix_out;
  logic                  pix_out_valid;
  logic                  key_underrun;
  logic                  line_overflow;

  modport master (
    output line_start, pix_in, pix_in_valid, key_in, key_valid, bypass,
    input  pix_out, pix_out_valid, key_underrun, line_overflow
  );

  modport slave (
    input  line_start, pix_in, pix_in_valid, key_in, key_valid, bypass,
    output pix_out, pix_out_valid, key_underrun, line_overflow
  );
endinterface

// File: rtl/line_cut_rotate_scrambler.sv
// Ping-pong line buffer that replays each stored line starting at a key-derived
// cut point and wrapping around, one line plus 2 clk behind the input.
module line_cut_rotate_scrambler #(
  parameter int DATA_WIDTH  = 10,
  parameter int LINE_PIXELS = 1440,
  parameter int KEY_WIDTH   = 8,
  parameter int CUT_SHIFT   = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  line_cut_rotate_scrambler_if.slave   bus
);
  localparam int ADDR_W = $clog2(LINE_PIXELS) + 1;
  localparam int KS_W   = KEY_WIDTH + CUT_SHIFT;
  localparam int CMP_W  = (KS_W > ADDR_W) ? KS_W : ADDR_W;
  localparam logic [ADDR_W-1:0] LP_A = ADDR_W'(LINE_PIXELS);

  logic [DATA_WIDTH-1:0] r_mem [0:2*LINE_PIXELS-1];

  logic                  r_wbank;
  logic [ADDR_W-1:0]     r_wcnt;
  logic [ADDR_W-1:0]     r_rcnt;
  logic [ADDR_W-1:0]     r_prev_len;
  logic [KEY_WIDTH-1:0]  r_key_pending;
  logic                  r_key_fresh;
  logic [KEY_WIDTH-1:0]  r_key_active;
  logic                  r_bypass;
  logic                  r_started;
  logic                  r_rd_en;
  logic [ADDR_W-1:0]     r_raddr;
  logic [DATA_WIDTH-1:0] r_pix_out;
  logic                  r_pix_out_valid;
  logic                  r_key_underrun;
  logic                  r_line_overflow;

  logic [KEY_WIDTH-1:0]  w_key_sel;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_W-1:0]     w_waddr;
  logic [CMP_W-1:0]      w_key_shift;
  logic [ADDR_W-1:0]     w_cut;
  logic [ADDR_W-1:0]     w_sum;
  logic [ADDR_W-1:0]     w_raddr;
  logic [ADDR_W-1:0]     w_raddr_flat;

  // A key arriving on the line_start clk is used for that very swap.
  assign w_key_sel = bus.key_valid ? bus.key_in : r_key_pending;

  assign w_wr_ok = bus.pix_in_valid && (r_wcnt < LP_A);
  assign w_rd_ok = bus.pix_in_valid && (r_rcnt < r_prev_len);
  assign w_waddr = (r_wbank ? LP_A : '0) + r_wcnt;

  // Cut is compared wide so a large key cannot wrap into a small false cut.
  assign w_key_shift = CMP_W'(r_key_active) << CUT_SHIFT;
  assign w_cut = (r_bypass || (w_key_shift >= CMP_W'(r_prev_len)))
                 ? '0 : w_key_shift[ADDR_W-1:0];

  // cut < prev_len and rcnt < prev_len, so one subtract wraps the address.
  assign w_sum        = w_cut + r_rcnt;
  assign w_raddr      = (w_sum >= r_prev_len) ? (w_sum - r_prev_len) : w_sum;
  assign w_raddr_flat = (r_wbank ? '0 : LP_A) + w_raddr;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_waddr] <= bus.pix_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wbank         <= 1'b0;
      r_wcnt          <= '0;
      r_rcnt          <= '0;
      r_prev_len      <= '0;
      r_key_pending   <= '0;
      r_key_fresh     <= 1'b0;
      r_key_active    <= '0;
      r_bypass        <= 1'b0;
      r_started       <= 1'b0;
      r_rd_en         <= 1'b0;
      r_raddr         <= '0;
      r_pix_out       <= '0;
      r_pix_out_valid <= 1'b0;
      r_key_underrun  <= 1'b0;
      r_line_overflow <= 1'b0;
    end else begin
      r_key_underrun <= 1'b0;
      if (bus.key_valid) begin
        r_key_pending <= bus.key_in;
        r_key_fresh   <= 1'b1;
      end
      if (bus.line_start) begin
        r_key_active   <= w_key_sel;
        r_key_fresh    <= 1'b0;
        r_key_underrun <= !r_key_fresh && !bus.key_valid;
        r_bypass       <= bus.bypass;
        // Samples seen before the first line_start after reset are never replayed.
        r_prev_len     <= r_started ? r_wcnt : '0;
        r_started      <= 1'b1;
        r_wbank        <= ~r_wbank;
        r_wcnt         <= '0;
        r_rcnt         <= '0;
      end else begin
        if (w_wr_ok) r_wcnt <= r_wcnt + ADDR_W'(1);
        if (w_rd_ok) r_rcnt <= r_rcnt + ADDR_W'(1);
      end
      if (bus.pix_in_valid && !w_wr_ok) r_line_overflow <= 1'b1;

      // The flat read address carries the bank, so a swap cannot disturb issued reads.
      r_rd_en <= w_rd_ok;
      if (w_rd_ok) r_raddr <= w_raddr_flat;
      r_pix_out_valid <= r_rd_en;
      if (r_rd_en) r_pix_out <= r_mem[r_raddr];
    end
  end

  assign bus.pix_out       = r_pix_out;
  assign bus.pix_out_valid = r_pix_out_valid;
  assign bus.key_underrun  = r_key_underrun;
  assign bus.line_overflow = r_line_overflow;
endmodule

// File: tb/tb_line_cut_rotate_scrambler.sv
// Directed bench for the cut-and-rotate scrambler with 16-sample lines.
module tb_line_cut_rotate_scrambler;
  localparam int DW = 10;
  localparam int KW = 8;
  localparam int LP = 16;

  logic clk;
  logic reset_n;

  line_cut_rotate_scrambler_if #(.DATA_WIDTH(DW), .KEY_WIDTH(KW)) bus ();

  line_cut_rotate_scrambler #(
    .DATA_WIDTH(DW), .LINE_PIXELS(LP), .KEY_WIDTH(KW), .CUT_SHIFT(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic          pend_v;
  logic [DW-1:0] pend_d;
  int            last_line [0:LP-1];
  int            cur_line  [0:LP-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One clk of stimulus; afterwards the previous cycle's expectation is checked.
  task automatic drive_cycle(input bit ls, input bit v, input int d, input bit kv,
                             input int k, input bit byp, input bit ev, input int ed,
                             input bit eu);
    bus.line_start   = ls;
    bus.pix_in_valid = v;
    bus.pix_in       = DW'(d);
    bus.key_valid    = kv;
    bus.key_in       = KW'(k);
    bus.bypass       = byp;
    @(posedge clk);
    #1;
    check("pix_out_valid", 32'(bus.pix_out_valid), 32'(pend_v));
    if (pend_v) check("pix_out", 32'(bus.pix_out), 32'(pend_d));
    check("key_underrun", 32'(bus.key_underrun), 32'(eu));
    pend_v = ev;
    pend_d = DW'(ed);
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_key(input int k);
    drive_cycle(0, 0, 0, 1, k, 0, 0, 0, 0);
  endtask

  task automatic start_line(input bit kv, input int k, input bit byp, input bit eu);
    drive_cycle(1, 0, 0, kv, k, byp, 0, 0, eu);
  endtask

  // Samples base+j; expected output is the previous line rotated by cut over plen.
  task automatic send_line(input int n, input int base, input int cut, input int plen,
                           input bit gaps);
    for (int j = 0; j < n; j++) begin
      if (j < plen)
        drive_cycle(0, 1, base + j, 0, 0, 0, 1, last_line[(cut + j) % plen], 0);
      else
        drive_cycle(0, 1, base + j, 0, 0, 0, 0, 0, 0);
      if (j < LP) cur_line[j] = base + j;
      if (gaps && (j % 2 == 0)) idle();
    end
    for (int j = 0; j < LP; j++) last_line[j] = cur_line[j];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pend_v = 1'b0;
    pend_d = '0;
    for (int j = 0; j < LP; j++) begin
      last_line[j] = 0;
      cur_line[j]  = 0;
    end
    reset_n          = 1'b0;
    bus.line_start   = 1'b0;
    bus.pix_in       = '0;
    bus.pix_in_valid = 1'b0;
    bus.key_in       = '0;
    bus.key_valid    = 1'b0;
    bus.bypass       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_out", 32'(bus.pix_out), 0);
    check("rst_pix_out_valid", 32'(bus.pix_out_valid), 0);
    check("rst_key_underrun", 32'(bus.key_underrun), 0);
    check("rst_line_overflow", 32'(bus.line_overflow), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // first line_start has no fresh key and nothing to replay
    start_line(0, 0, 0, 1);
    send_line(16, 0, 0, 0, 0);
    idle();

    // key 2 -> cut 8: 8..15,0..7
    load_key(2);
    start_line(0, 0, 0, 0);
    send_line(16, 100, 8, 16, 0);
    idle();
    check("overflow_at_exact_len", 32'(bus.line_overflow), 0);

    // bypass -> in order
    load_key(3);
    start_line(0, 0, 1, 0);
    send_line(16, 200, 0, 16, 0);
    idle();

    // key 5 -> cut 20 >= 16 -> 0; short line of 12
    load_key(5);
    start_line(0, 0, 0, 0);
    send_line(12, 300, 0, 16, 0);
    idle();

    // key 2 over a 12-sample line: 8..11,0..7 then invalid
    load_key(2);
    start_line(0, 0, 0, 0);
    send_line(16, 400, 8, 12, 0);
    idle();

    // no key: underrun pulse, previous key (cut 8) reused
    start_line(0, 0, 0, 1);
    send_line(16, 500, 8, 16, 0);
    idle();

    // key coincident with line_start, key 1 -> cut 4, gapped input
    start_line(1, 1, 0, 0);
    send_line(16, 600, 4, 16, 1);
    idle();

    // 18 samples: overflow, last two dropped
    start_line(1, 0, 0, 0);
    send_line(18, 700, 0, 16, 0);
    idle();
    check("overflow_set", 32'(bus.line_overflow), 1);

    // key 3 -> cut 12 over prev_len 16
    start_line(1, 3, 0, 0);
    send_line(16, 800, 12, 16, 0);
    idle();
    check("overflow_sticky", 32'(bus.line_overflow), 1);

    // reset mid-line
    start_line(1, 0, 0, 0);
    send_line(5, 900, 0, 16, 0);
    reset_n = 1'b0;
    #1;
    check("midrst_pix_out", 32'(bus.pix_out), 0);
    check("midrst_pix_out_valid", 32'(bus.pix_out_valid), 0);
    check("midrst_line_overflow", 32'(bus.line_overflow), 0);
    pend_v = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_line(11, 905, 0, 0, 0);
    start_line(1, 0, 0, 0);
    send_line(16, 960, 0, 0, 0);
    idle();

    // normal operation resumes on the next line
    start_line(1, 0, 0, 0);
    send_line(16, 30, 0, 16, 0);
    idle();
    idle();
    check("overflow_after_reset", 32'(bus.line_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
